inst_manager: RTL and testbench
===============================

Name: inst_manager

Overview:
- Instruction prefetch unit for the PANZER16 CPU front end.
- After a program-counter load (Set/AdessIn), it fetches sequential 16-bit instruction words over a simple read-only request/ready bus and buffers them in a small FIFO.
- The decode stage reads the FIFO head on InstructionOut and pops it with Dequeue.
- It sits between the core's fetch control and the instruction ROM/bus slave.

Parameters:
- DEPTH, 4, prefetch FIFO depth in 16-bit words. Must be a power of two, at least 2.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Dequeue  input  1  pop FIFO head at this edge; ignored when Empty=1.
- PReady  input  1  bus slave ready; a beat completes on an edge where Trans=1 and PReady=1.
- Set  input  1  load fetch pointer from AdessIn and flush the FIFO.
- AdessIn  input  16  new fetch address, sampled while Set=1.
- PDataIn  input  16  read data from the slave, captured on a completing edge.
- Empty  output  1  FIFO holds no valid instruction.
- Busy  output  1  fetch engine is in the FETCH state.
- Trans  output  1  bus read request.
- AdressOut  output  16  word address of the current/next fetch (current fetch pointer).
- InstructionOut  output  16  FIFO head word; 0 when Empty=1.

Behaviour:
- One clock domain (Clk). RST is synchronous and active-high.
- Reset values:
  - FIFO cleared; Empty=1, InstructionOut=0.
  - Fetch pointer = 0, so AdressOut=0.
  - State IDLE, so Trans=0, Busy=0.
  - No fetching occurs after reset until the first Set.
- State machine:
  - IDLE: Trans=0, Busy=0.
  - FETCH: Trans=1, Busy=1, AdressOut=fetch pointer.
  - Trans and Busy are registered state decodes.
- Priority at each edge: RST > Set > normal operation.
- Set=1 edge:
  - Fetch pointer <= AdessIn; FIFO flushed (count=0).
  - State <= IDLE; any beat in flight is abandoned and its PReady/PDataIn are ignored.
  - A Dequeue in the same edge is ignored.
  - Set may be held for many cycles; each edge reloads and flushes.
- Set=0, IDLE: if the FIFO is not full and at least one Set has occurred since reset, go to FETCH next edge.
- Set=0, FETCH, PReady=1 (beat completes):
  - Push PDataIn at the FIFO tail; fetch pointer += 1 (16-bit wrap, 0xFFFF -> 0x0000).
  - Stay in FETCH if post-edge occupancy < DEPTH (accounting for a same-edge Dequeue); otherwise go to IDLE.
- FETCH, PReady=0: hold; AdressOut and Trans stay stable (unbounded wait states allowed).
- Dequeue=1 with Empty=0 pops the head.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pop while full allows fetching to continue or resume next cycle.
- InstructionOut and Empty are combinational from FIFO contents: next word visible in the same cycle after the pop edge.
- Latency:
  - Set falling: first Trans one cycle after the last Set edge.
  - Zero-wait slave (PReady=1): Empty falls on the next edge; one word per cycle thereafter until full.
- Full FIFO with no Dequeue: Trans=0, pointer holds at last-fetched+1.
- FIFO pointers are log2(DEPTH) bits with wrap; count is log2(DEPTH)+1 bits.

Test Plan:
- Bench environment: a 1024-word memory slave model, preloaded so mem[i] is a known random value. The slave answers Trans with PReady the same cycle; an optional mode adds 2 wait states.
- Reset: hold RST for 7 cycles -> Empty=1, Trans=0, Busy=0, AdressOut=0, InstructionOut=0. With no Set, Trans stays 0.
- Set=1, AdessIn=69 for one edge -> Trans=1 next cycle with AdressOut=69. FIFO fills with mem[69..72]; InstructionOut=mem[69]; Trans=0, Busy=0, AdressOut=73 once full.
- Set=1, AdessIn=68 held 5 edges while full -> Empty=1 and Trans=0 during Set. After release, fetch mem[68..71]; AdressOut=72 when full.
- Dequeue held 4 cycles on a full FIFO -> InstructionOut steps mem[68], mem[69], mem[70], mem[71]. Refill fetches 72, 73, ... with no lost or duplicated words; final head is mem[72] and the FIFO refills to full.
- Wait-state slave -> AdressOut/Trans stable until PReady. A Set mid-wait discards that beat (no push) and restarts at the new address. Dequeue on Empty is ignored (count stays 0).
- Wrap: Set AdessIn=0xFFFE -> words fetched from 0xFFFE, 0xFFFF, 0x0000, 0x0001. RST asserted mid-fetch -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/inst_manager.sv
// Instruction prefetch unit: fetches sequential 16-bit words after a pointer
// load and buffers them in a small FIFO for the decode stage.
module inst_manager #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        RST,
    input  logic        Dequeue,
    input  logic        PReady,
    input  logic        Set,
    input  logic [15:0] AdessIn,
    input  logic [15:0] PDataIn,
    output logic        Empty,
    output logic        Busy,
    output logic        Trans,
    output logic [15:0] AdressOut,
    output logic [15:0] InstructionOut
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]    state;
    logic          armed;
    logic [15:0]   fetch_ptr;
    logic [15:0]   fifo [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    // Beat completion, head pop and the resulting occupancy for this edge
    always_comb begin
        pop        = Dequeue && (count != '0);
        push       = (state == FETCH) && PReady;
        count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // Fetch engine, pointer load/flush and FIFO bookkeeping
    always_ff @(posedge Clk) begin
        if (RST) begin
            state     <= IDLE;
            armed     <= 1'b0;
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (Set) begin
            state     <= IDLE;
            armed     <= 1'b1;
            fetch_ptr <= AdessIn;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                fetch_ptr <= fetch_ptr + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            case (state)
                IDLE:    if (armed && (count_next < FULL)) state <= FETCH;
                FETCH:   if (push && (count_next == FULL)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; a beat landing on a Set or reset edge is dropped
    always_ff @(posedge Clk) begin
        if (!RST && !Set && push) begin
            fifo[wr_ptr] <= PDataIn;
        end
    end

    // Outputs decoded from registered state and FIFO contents
    always_comb begin
        Empty          = (count == '0);
        InstructionOut = Empty ? '0 : fifo[rd_ptr];
        Trans          = (state == FETCH);
        Busy           = (state == FETCH);
        AdressOut      = fetch_ptr;
    end

endmodule

// File: tb/tb_inst_manager.sv
// Randomized bench for inst_manager with a queue-based prefetch model and a
// 1024-word memory slave (zero-wait, 2-wait-state or random-ready modes).
module tb_inst_manager;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        RST;
    logic        Dequeue;
    logic        PReady;
    logic        Set;
    logic [15:0] AdessIn;
    logic [15:0] PDataIn;
    logic        Empty;
    logic        Busy;
    logic        Trans;
    logic [15:0] AdressOut;
    logic [15:0] InstructionOut;

    inst_manager #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .RST(RST), .Dequeue(Dequeue), .PReady(PReady), .Set(Set),
        .AdessIn(AdessIn), .PDataIn(PDataIn), .Empty(Empty), .Busy(Busy),
        .Trans(Trans), .AdressOut(AdressOut), .InstructionOut(InstructionOut)
    );

    always #5 Clk = ~Clk;

    logic [15:0] mem [1024];
    int          n_cmp = 0;
    int          n_err = 0;

    // slave modes
    logic        wmode = 1'b0;
    logic        rmode = 1'b0;
    int          wcnt  = 0;

    // reference model state
    logic [15:0] q [$];
    logic [15:0] mptr   = '0;
    logic        mfetch = 1'b0;
    logic        marmed = 1'b0;

    function automatic logic [34:0] expv();
        logic        e;
        logic [15:0] head;
        e    = (q.size() == 0);
        head = e ? 16'h0000 : q[0];
        return {e, mfetch, mfetch, mptr, head};
    endfunction

    // one clock: slave answers, edge, model update, settle to negedge
    task automatic tick();
        logic tr;
        tr = Trans;
        if (!tr)        PReady = 1'b0;
        else if (rmode) PReady = ($urandom_range(2) != 0);
        else if (wmode) PReady = (wcnt == 2);
        else            PReady = 1'b1;
        PDataIn = mem[AdressOut[9:0]];
        @(posedge Clk);
        if (RST) begin
            q.delete(); mptr = '0; mfetch = 1'b0; marmed = 1'b0;
        end else if (Set) begin
            q.delete(); mptr = AdessIn; mfetch = 1'b0; marmed = 1'b1;
        end else begin
            logic pushm;
            pushm = mfetch && PReady;
            if (Dequeue && q.size() > 0) void'(q.pop_front());
            if (pushm) begin
                q.push_back(mem[mptr[9:0]]);
                mptr = mptr + 16'd1;
            end
            if (mfetch) mfetch = pushm ? (q.size() < DEPTH) : 1'b1;
            else        mfetch = marmed && (q.size() < DEPTH);
        end
        if (RST || Set || !tr || PReady) wcnt = 0;
        else                             wcnt = wcnt + 1;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        RST = 1'b1; Set = 1'b0; Dequeue = 1'b0; AdessIn = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
                n_err++;
                $display("FAIL reset: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, {1'b1, 34'h0});
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (Trans !== 1'b0 || {Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL no_set_idle: trans=%b got %h want %h", Trans, {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
    endtask

    task automatic test_fill();
        Set = 1'b1; AdessIn = 16'd69;
        tick();
        Set = 1'b0;
        tick();
        n_cmp++;
        if (Trans !== 1'b1 || AdressOut !== 16'd69) begin
            n_err++;
            $display("FAIL first_trans: trans=%b addr=%h want 1 0045", Trans, AdressOut);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL fill: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
        n_cmp++;
        if ({InstructionOut, AdressOut, Trans, Busy} !== {mem[69], 16'd73, 2'b00}) begin
            n_err++;
            $display("FAIL fill_full: got %h want %h", {InstructionOut, AdressOut, Trans, Busy}, {mem[69], 16'd73, 2'b00});
        end
    endtask

    task automatic test_set_hold();
        Set = 1'b1; AdessIn = 16'd68;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (Empty !== 1'b1 || Trans !== 1'b0 || AdressOut !== 16'd68) begin
                n_err++;
                $display("FAIL set_hold: empty=%b trans=%b addr=%h want 1 0 0044", Empty, Trans, AdressOut);
            end
        end
        Set = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL set_refill: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
        n_cmp++;
        if (AdressOut !== 16'd72 || InstructionOut !== mem[68] || Trans !== 1'b0) begin
            n_err++;
            $display("FAIL set_full: addr=%h head=%h trans=%b want 0048 %h 0", AdressOut, InstructionOut, Trans, mem[68]);
        end
    endtask

    task automatic test_dequeue();
        Dequeue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (InstructionOut !== mem[68 + i]) begin
                n_err++;
                $display("FAIL deq_head%0d: got %h want %h", i, InstructionOut, mem[68 + i]);
            end
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL deq_model: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
        Dequeue = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL deq_refill: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
        n_cmp++;
        if (InstructionOut !== mem[72] || AdressOut !== 16'd76 || Trans !== 1'b0) begin
            n_err++;
            $display("FAIL deq_final: head=%h addr=%h trans=%b want %h 004c 0", InstructionOut, AdressOut, Trans, mem[72]);
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] pa;
        int          guard;
        wmode = 1'b1;
        Set = 1'b1; AdessIn = 16'd100;
        tick();
        Set = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pa = AdressOut;
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv() ||
                (wcnt != 0 && (AdressOut !== pa || Trans !== 1'b1))) begin
                n_err++;
                $display("FAIL wait_stable: got %h want %h prev_addr=%h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv(), pa);
            end
        end
        // drain a little so a beat is in flight, then abort it with Set
        Dequeue = 1'b1;
        guard = 0;
        while (wcnt != 1 && guard < 20) begin
            tick();
            guard++;
        end
        Dequeue = 1'b0;
        n_cmp++;
        if (wcnt != 1) begin
            n_err++;
            $display("FAIL wait_reach: wcnt=%0d want 1", wcnt);
        end
        Set = 1'b1; AdessIn = 16'd200; Dequeue = 1'b1;
        tick();
        Set = 1'b0;
        tick();
        n_cmp++;
        if (Empty !== 1'b1 || {Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
            n_err++;
            $display("FAIL deq_empty: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
        end
        Dequeue = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL wait_restart: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
        n_cmp++;
        if (InstructionOut !== mem[200] || AdressOut !== 16'd204) begin
            n_err++;
            $display("FAIL wait_final: head=%h addr=%h want %h 00cc", InstructionOut, AdressOut, mem[200]);
        end
        wmode = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        logic [15:0] exp_addr [4];
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        Set = 1'b1; AdessIn = 16'hFFFE;
        tick();
        Set = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (AdressOut !== 16'h0002 || {Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
            n_err++;
            $display("FAIL wrap_ptr: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
        end
        Dequeue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (InstructionOut !== mem[exp_addr[i][9:0]]) begin
                n_err++;
                $display("FAIL wrap_word%0d: got %h want %h", i, InstructionOut, mem[exp_addr[i][9:0]]);
            end
            tick();
        end
        Dequeue = 1'b0;
        Set = 1'b1; AdessIn = 16'd10;
        tick();
        Set = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        n_cmp++;
        if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== {1'b1, 34'h0}) begin
            n_err++;
            $display("FAIL mid_reset: got %h want %h", {Empty, Busy, Trans, AdressOut, InstructionOut}, {1'b1, 34'h0});
        end
        RST = 1'b0;
    endtask

    task automatic test_random();
        rmode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            Dequeue = ($urandom_range(1) == 1);
            Set     = ($urandom_range(24) == 0);
            AdessIn = 16'($urandom);
            tick();
            n_cmp++;
            if ({Empty, Busy, Trans, AdressOut, InstructionOut} !== expv()) begin
                n_err++;
                $display("FAIL random%0d: got %h want %h", i, {Empty, Busy, Trans, AdressOut, InstructionOut}, expv());
            end
        end
        Set = 1'b0; Dequeue = 1'b0; rmode = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        RST = 1'b1; Set = 1'b0; Dequeue = 1'b0; AdessIn = '0; PReady = 1'b0; PDataIn = '0;
        test_reset();
        test_fill();
        test_set_hold();
        test_dequeue();
        test_wait_states();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
